mult_seq_unit: RTL and testbench
================================

Name: mult_seq_unit

Overview:
- Iterative radix-2 shift-add sequencer for the MULT instruction. Accepts signed operands from the execute stage and produces a 64-bit product into internal HI/LO registers.
- Holds the pipeline via stall_req while it computes.
- Supports abort on pipeline flush.
- Sits beside the ALU in execute. Its start input comes from the decoded MULT pnemonic in X.

Parameters:
- DATA_W, 32, operand width; product is 2*DATA_W bits.
- CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  MULT present in X stage (instr_pnem_X == NEM_MULT).
- flush  input  1  X-stage flush; aborts an in-flight multiply.
- operand_a  input  DATA_W  signed multiplicand (rs value, forwarded).
- operand_b  input  DATA_W  signed multiplier (rt value, forwarded).
- stall_req  output  1  freeze F/D/X and insert a bubble in M.
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle pulse: product valid this cycle.
- product_hi  output  DATA_W  HI register, upper half of product.
- product_lo  output  DATA_W  LO register, lower half of product.

Behaviour:
- Reset (async, any state) puts the FSM in IDLE and clears the counter, accumulator and product_hi/lo to 0. Outputs then read stall_req=0, busy=0, done=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0 accepts the operation (cycle 0).
  - Latch |a| and |b| as unsigned DATA_W values, so -2^(DATA_W-1) maps to 2^(DATA_W-1) with no overflow.
  - Latch neg = a[MSB]^b[MSB]. Clear the accumulator and counter. Go to CALC.
- CALC, one iteration per cycle:
  - If multiplier LSB is 1, add the multiplicand into the upper half of the 2*DATA_W+1 accumulator.
  - Shift the accumulator right by 1. Increment the counter.
  - When counter == DATA_W-1 at the clock edge, go to DONE.
  - CALC therefore spans cycles 1..DATA_W.
- Entry into DONE:
  - Write the final magnitude, two's-complement negated if neg, into product_hi/product_lo.
- DONE (cycle DATA_W+1): done=1, busy=1, stall_req=0. Go to IDLE unconditionally next cycle.
- stall_req = (IDLE & start & ~flush) | CALC. It is combinational so the pipeline freezes in the accept cycle.
  - Total stall is DATA_W+1 cycles (33 at default).
- product_hi/lo hold their value from DONE until the next DONE. They do not change during CALC.
- flush in IDLE with start=1: flush wins. No accept, no stall.
- flush during CALC: return to IDLE next cycle, stall_req drops that cycle. No done pulse; product_hi/lo keep their old values.
- flush during DONE: ignored. The result is already committed.
- start while CALC/DONE: ignored. Operands are not relatched.
- start in IDLE the cycle right after DONE: accepted normally, which allows back-to-back MULTs.
- Zero operand: still takes the full DATA_W iterations. No early termination.

Test Plan:
- Reset, then a=7, b=6, start pulse:
  - stall_req high for exactly 33 cycles.
  - done in cycle 33 after accept.
  - product_hi=0x00000000, product_lo=0x0000002A.
- a=-3 (0xFFFFFFFD), b=5: product_hi=0xFFFFFFFF, product_lo=0xFFFFFFF1.
- a=b=0x80000000: product_hi=0x40000000, product_lo=0x00000000.
- Preload product via 2x3, then start 9x9 and assert flush at cycle 10:
  - stall_req low by cycle 11, no done.
  - product stays hi=0, lo=6.
  - Start held constant in the same cycle as flush is not accepted.
- Assert rst asynchronously (between clock edges) at cycle 15 of a multiply:
  - Outputs go to 0 immediately without waiting for a clock edge.
  - After release, a new 4x4 gives lo=0x10.
- Back-to-back 2x3 then 4x5, start high again right after done:
  - Second done exactly 34 cycles after the first, lo=0x14.
  - A start pulse mid-CALC does not change the result.

Source files
------------

// File: rtl/mult_seq_unit.sv
// mult_seq_unit: iterative radix-2 shift-add signed multiplier for MULT,
// stalling the pipeline while it computes and aborting on X-stage flush.
module mult_seq_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   output logic              stall_req,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product_hi,
   output logic [DATA_W-1:0] product_lo
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*DATA_W:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
   logic                neg_q, neg_d;
   logic                accept;
   logic [DATA_W:0]     sum;
   logic [2*DATA_W-1:0] mag;
   logic [DATA_W-1:0]   abs_a, abs_b;
   assign accept = (state_q == IDLE) && start && !flush;
   assign abs_a  = operand_a[DATA_W-1] ? -operand_a : operand_a;
   assign abs_b  = operand_b[DATA_W-1] ? -operand_b : operand_b;
   // Lower half carries the multiplier; product bits shift in from the top.
   assign sum    = acc_q[2*DATA_W:DATA_W] + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign mag    = {sum, acc_q[DATA_W-1:1]};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = CALC;
            cnt_d   = '0;
            acc_d   = {{(DATA_W+1){1'b0}}, abs_b};
            mcand_d = abs_a;
            neg_d   = operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
         end
         CALC: if (flush) state_d = IDLE;
         else begin
            acc_d = {1'b0, mag};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W-1)) begin
               state_d      = DONE;
               {hi_d, lo_d} = neg_q ? -mag : mag;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
   assign stall_req  = accept || (state_q == CALC && !flush);
   assign busy       = state_q != IDLE;
   assign done       = state_q == DONE;
   assign product_hi = hi_q;
   assign product_lo = lo_q;
endmodule

// File: tb/tb_mult_seq_unit.sv
// tb_mult_seq_unit: scoreboard bench for mult_seq_unit; expected products are
// queued at issue and compared when done pulses.
module tb_mult_seq_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        stall_req, busy, done;
   logic [31:0] product_hi, product_lo;
   int          tests = 0;
   int          fails = 0;
   int          cyc_cnt = 0;
   int          ndone = 0;
   int          last_done = 0;
   logic [63:0] sb[$];

   mult_seq_unit dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush),
      .operand_a(operand_a), .operand_b(operand_b),
      .stall_req(stall_req), .busy(busy), .done(done),
      .product_hi(product_hi), .product_lo(product_lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb_;
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      return 64'(sa * sb_);
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         ndone <= ndone + 1;
         last_done <= cyc_cnt;
         if (sb.size() == 0) check("unexpected_done", 64'(sb.size()), 64'd1);
         else check("sb_product", {product_hi, product_lo}, sb.pop_front());
      end
   end

   // Issues one MULT; pulse_at > 0 re-asserts start with junk operands mid-CALC.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                         output int nst, output int dcyc);
      @(posedge clk); #1;
      start = 1'b1; operand_a = a; operand_b = b;
      sb.push_back(model(a, b));
      nst = 0; dcyc = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (stall_req) nst++;
         if (done) begin dcyc = c; break; end
         @(posedge clk); #1;
         start = (c + 1 == pulse_at);
         if (c + 1 == pulse_at) begin operand_a = 32'h0000_0077; operand_b = 32'hdead_beef; end
      end
      start = 1'b0;
      #1;
   endtask

   initial begin
      int nst, dcyc, d1, nd;
      #22 rst = 1'b0;
      @(negedge clk);
      check("rst_stall", stall_req, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_prod", {product_hi, product_lo}, 0);

      run_op(32'd7, 32'd6, 0, nst, dcyc);
      check("7x6_stall_cycles", nst, 33);
      check("7x6_done_cycle", dcyc, 33);
      check("7x6_prod", {product_hi, product_lo}, 64'h0000_0000_0000_002A);

      run_op(32'hFFFF_FFFD, 32'd5, 0, nst, dcyc);
      check("m3x5_prod", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFF1);

      run_op(32'h8000_0000, 32'h8000_0000, 0, nst, dcyc);
      check("min_sq_prod", {product_hi, product_lo}, 64'h4000_0000_0000_0000);

      run_op(32'd2, 32'd3, 0, nst, dcyc);
      nd = ndone;
      @(posedge clk); #1;
      start = 1'b1; operand_a = 32'd9; operand_b = 32'd9;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 10) flush = 1'b1;
      end
      @(negedge clk);
      check("flush_prod_hold", {product_hi, product_lo}, 64'd6);
      @(posedge clk); #1;
      @(negedge clk);
      check("flush_stall_c11", stall_req, 0);
      check("flush_busy_c11", busy, 0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      repeat (40) @(negedge clk);
      check("flush_no_done", ndone, nd);
      check("flush_prod", {product_hi, product_lo}, 64'd6);

      @(posedge clk); #1;
      start = 1'b1; operand_a = 32'd5; operand_b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_stall", stall_req, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_prod", {product_hi, product_lo}, 0);
      @(negedge clk); #2 rst = 1'b0;
      run_op(32'd4, 32'd4, 0, nst, dcyc);
      check("4x4_prod", {product_hi, product_lo}, 64'h10);

      run_op(32'd2, 32'd3, 0, nst, dcyc);
      d1 = last_done;
      run_op(32'd4, 32'd5, 12, nst, dcyc);
      check("b2b_gap", last_done - d1, 34);
      check("b2b_prod", {product_hi, product_lo}, 64'h14);

      repeat (40) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
